// File: rtl/conv_out_serializer.sv
// conv_out_serializer: splits each wide Conv2D3x3 output beat (all filters of one pixel)
// into FILTERS narrow beats in filter order, flagging the last word of every frame.
// Latency 1 cycle from accept to first word; two-slot buffer; upstream stalls when both slots are full.
//
// Ports:
//   i_aclk, i_areset          clock (rising edge) and synchronous active-high reset
//   i_tvalid/o_tready/i_tdata wide upstream beat, filter f at [f*WORD_WIDTH +: WORD_WIDTH]
//   o_tvalid/i_tready/o_tdata narrow downstream beat, one filter word per handshake
//   o_tlast                   high on the final word of the final pixel of a frame
//
// Optional build macro CONV_SER_RELU_EN: words are treated as signed and negative
// values are clamped to zero as they are loaded into the o_tdata register.
// Without it, words pass through bit-exact.

module conv_out_serializer #(
  parameter int WORD_WIDTH = 8,
  parameter int FILTERS    = 8,
  parameter int OUT_HEIGHT = 2,
  parameter int OUT_WIDTH  = 2
) (
  input  logic                          i_aclk,
  input  logic                          i_areset,
  input  logic                          i_tvalid,
  output logic                          o_tready,
  input  logic [WORD_WIDTH*FILTERS-1:0] i_tdata,
  input  logic                          i_tready,
  output logic                          o_tvalid,
  output logic [WORD_WIDTH-1:0]         o_tdata,
  output logic                          o_tlast
);

  localparam int BEAT_W = WORD_WIDTH * FILTERS;
  localparam int PIXELS = OUT_HEIGHT * OUT_WIDTH;
  localparam int WIDX_W = (FILTERS > 1) ? $clog2(FILTERS) : 1;
  localparam int PIDX_W = (PIXELS > 1) ? $clog2(PIXELS) : 1;

  localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(FILTERS - 1);
  localparam logic [PIDX_W-1:0] LAST_PIX  = PIDX_W'(PIXELS - 1);

  // Slot occupancy: EMPTY = no pixel, SEND = CUR only, FULL = CUR and NXT.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_SEND  = 2'd1,
    S_FULL  = 2'd2
  } slot_state_t;

  slot_state_t          r_state;
  logic [BEAT_W-1:0]    r_cur;
  logic [BEAT_W-1:0]    r_nxt;
  logic [WIDX_W-1:0]    r_w;
  logic [PIDX_W-1:0]    r_p;
  logic                 r_tvalid;
  logic [WORD_WIDTH-1:0] r_tdata;
  logic                 r_tlast;
  logic                 r_tready;

  // Select one filter word out of a wide beat.
  function automatic logic [WORD_WIDTH-1:0] word_at(input logic [BEAT_W-1:0] beat,
                                                    input logic [WIDX_W-1:0] idx);
    logic [WORD_WIDTH-1:0] v;
    v = '0;
    for (int f = 0; f < FILTERS; f++) begin
      if (idx == WIDX_W'(f)) begin
        v = beat[f*WORD_WIDTH +: WORD_WIDTH];
      end
    end
    return v;
  endfunction

`ifdef CONV_SER_RELU_EN
  // Signed clamp: any negative word becomes zero.
  function automatic logic [WORD_WIDTH-1:0] clamp_word(input logic [WORD_WIDTH-1:0] v);
    return v[WORD_WIDTH-1] ? '0 : v;
  endfunction
`else
  function automatic logic [WORD_WIDTH-1:0] clamp_word(input logic [WORD_WIDTH-1:0] v);
    return v;
  endfunction
`endif

  // o_tlast is a pure function of the word position being presented.
  function automatic logic last_flag(input logic [PIDX_W-1:0] p, input logic [WIDX_W-1:0] w);
    return (p == LAST_PIX) && (w == LAST_WORD);
  endfunction

  logic                  w_accept;
  logic                  w_hs;
  logic                  w_pix_done;
  logic [WIDX_W-1:0]     w_w_inc;
  logic [PIDX_W-1:0]     w_p_inc;
  logic [WORD_WIDTH-1:0] w_cur_adv;
  logic [WORD_WIDTH-1:0] w_in_word0;
  logic [WORD_WIDTH-1:0] w_nxt_word0;

  assign w_accept   = i_tvalid && r_tready;
  assign w_hs       = r_tvalid && i_tready;
  assign w_pix_done = w_hs && (r_w == LAST_WORD);
  assign w_w_inc    = r_w + WIDX_W'(1);
  assign w_p_inc    = (r_p == LAST_PIX) ? '0 : (r_p + PIDX_W'(1));

  // Candidate values for the o_tdata register: next word of CUR, or word 0 of a
  // beat that is about to become CUR (fresh input or promoted NXT).
  assign w_cur_adv   = clamp_word(word_at(r_cur, w_w_inc));
  assign w_in_word0  = clamp_word(word_at(i_tdata, '0));
  assign w_nxt_word0 = clamp_word(word_at(r_nxt, '0));

  // Single state machine; all outputs registered. r_tready always reflects the
  // state being entered, so o_tready depends on registered state only.
  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      r_state  <= S_EMPTY;
      r_cur    <= '0;
      r_nxt    <= '0;
      r_w      <= '0;
      r_p      <= '0;
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_tlast  <= 1'b0;
      r_tready <= 1'b0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          r_tready <= 1'b1;
          if (w_accept) begin
            r_cur    <= i_tdata;
            r_w      <= '0;
            r_tvalid <= 1'b1;
            r_tdata  <= w_in_word0;
            r_tlast  <= last_flag(r_p, '0);
            r_state  <= S_SEND;
          end
        end

        S_SEND: begin
          if (w_pix_done) begin
            r_p      <= w_p_inc;
            r_w      <= '0;
            r_tready <= 1'b1;
            if (w_accept) begin
              // Incoming beat replaces the finishing pixel directly: no bubble.
              r_cur   <= i_tdata;
              r_tdata <= w_in_word0;
              r_tlast <= last_flag(w_p_inc, '0);
            end else begin
              r_tvalid <= 1'b0;
              r_tlast  <= 1'b0;
              r_state  <= S_EMPTY;
            end
          end else begin
            if (w_hs) begin
              r_w     <= w_w_inc;
              r_tdata <= w_cur_adv;
              r_tlast <= last_flag(r_p, w_w_inc);
            end
            if (w_accept) begin
              r_nxt    <= i_tdata;
              r_tready <= 1'b0;
              r_state  <= S_FULL;
            end else begin
              r_tready <= 1'b1;
            end
          end
        end

        S_FULL: begin
          if (w_pix_done) begin
            // Promote NXT; its word 0 is presented on the very next cycle.
            r_cur    <= r_nxt;
            r_p      <= w_p_inc;
            r_w      <= '0;
            r_tdata  <= w_nxt_word0;
            r_tlast  <= last_flag(w_p_inc, '0);
            r_tready <= 1'b1;
            r_state  <= S_SEND;
          end else begin
            if (w_hs) begin
              r_w     <= w_w_inc;
              r_tdata <= w_cur_adv;
              r_tlast <= last_flag(r_p, w_w_inc);
            end
            r_tready <= 1'b0;
          end
        end

        default: begin
          r_state  <= S_EMPTY;
          r_tvalid <= 1'b0;
          r_tlast  <= 1'b0;
          r_tready <= 1'b1;
        end
      endcase
    end
  end

  assign o_tready = r_tready;
  assign o_tvalid = r_tvalid;
  assign o_tdata  = r_tdata;
  assign o_tlast  = r_tlast;

endmodule

// File: tb/tb_conv_out_serializer.sv
module tb_conv_out_serializer;

  localparam int W   = 8;
  localparam int F   = 8;
  localparam int OH  = 2;
  localparam int OW  = 2;
  localparam int DW  = W * F;
  localparam int PIX = OH * OW;

  logic          clk = 1'b0;
  logic          i_areset = 1'b1;
  logic          i_tvalid = 1'b0;
  logic          i_tready = 1'b0;
  logic [DW-1:0] i_tdata  = '0;
  logic          o_tready;
  logic          o_tvalid;
  logic [W-1:0]  o_tdata;
  logic          o_tlast;

  always #5 clk = ~clk;

  conv_out_serializer #(
    .WORD_WIDTH(W), .FILTERS(F), .OUT_HEIGHT(OH), .OUT_WIDTH(OW)
  ) dut (
    .i_aclk(clk), .i_areset(i_areset),
    .i_tvalid(i_tvalid), .o_tready(o_tready), .i_tdata(i_tdata),
    .i_tready(i_tready), .o_tvalid(o_tvalid), .o_tdata(o_tdata), .o_tlast(o_tlast)
  );

  typedef struct packed {
    logic [W-1:0] dat;
    logic         last;
  } exp_t;

  exp_t q[$];
  int   hs_cyc[$];
  int   acc_cyc[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_pop = 0;
  int   cyc = 0;
  int   m_pix = 0;
  int   rdy_mode = 0;
  int   pidx = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: word f of a beat is bits [f*W +: W]; optional signed clamp.
  function automatic logic [W-1:0] ref_word(input logic [DW-1:0] beat, input int f);
    logic [W-1:0] v;
    v = W'(beat >> (f * W));
`ifdef CONV_SER_RELU_EN
    if ($signed(v) < 0) v = '0;
`endif
    return v;
  endfunction

  task automatic model_push(input logic [DW-1:0] beat);
    exp_t e;
    for (int f = 0; f < F; f++) begin
      e.dat  = ref_word(beat, f);
      e.last = (m_pix == PIX - 1) && (f == F - 1);
      q.push_back(e);
    end
    m_pix = (m_pix + 1) % PIX;
  endtask

  // Downstream ready generator: always / 1,0,0,1 pattern / random.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: i_tready = 1'b1;
        1: begin
          i_tready = ((pidx % 4) == 0) || ((pidx % 4) == 3);
          pidx++;
        end
        default: i_tready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: pops the scoreboard on each handshake and checks stalled outputs hold.
  logic         stall_prev = 1'b0;
  logic [W-1:0] h_dat;
  logic         h_last;
  always @(negedge clk) begin
    if (i_areset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        n_cmp++;
        if (!(o_tvalid && o_tdata === h_dat && o_tlast === h_last)) begin
          n_fail++;
          $display("FAIL stall_hold: got v=%0b d=%0h l=%0b, expected v=1 d=%0h l=%0b",
                   o_tvalid, o_tdata, o_tlast, h_dat, h_last);
        end
      end
      if (o_tvalid && i_tready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_word: got d=%0h l=%0b, expected no word", o_tdata, o_tlast);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (o_tdata !== e.dat || o_tlast !== e.last) begin
            n_fail++;
            $display("FAIL word: got d=%0h l=%0b, expected d=%0h l=%0b",
                     o_tdata, o_tlast, e.dat, e.last);
          end
        end
        n_pop++;
        hs_cyc.push_back(cyc + 1);
      end
      stall_prev = o_tvalid && !i_tready;
      h_dat  = o_tdata;
      h_last = o_tlast;
    end
  end

  task automatic do_reset();
    i_areset = 1'b1;
    i_tvalid = 1'b1;
    i_tdata  = {$urandom, $urandom};
    q.delete();
    m_pix = 0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_tready", 64'(o_tready), 64'd0);
      chk("rst_tvalid", 64'(o_tvalid), 64'd0);
      chk("rst_tdata",  64'(o_tdata),  64'd0);
      chk("rst_tlast",  64'(o_tlast),  64'd0);
    end
    i_areset = 1'b0;
    i_tvalid = 1'b0;
    @(negedge clk);
    chk("tready_after_rst", 64'(o_tready), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input bit use_model);
    bit ok;
    ok = 1'b0;
    i_tvalid = 1'b1;
    i_tdata  = d;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      if (o_tready && !i_areset) begin
        ok = 1'b1;
        acc_cyc.push_back(cyc + 1);
        if (use_model) model_push(d);
      end
      @(posedge clk);
      #1;
    end
    i_tvalid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: got no accept, expected accept within 300 cycles");
    end
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 3000 && q.size() != 0; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({name, "_drained"}, 64'(q.size()), 64'd0);
    chk({name, "_idle_tvalid"}, 64'(o_tvalid), 64'd0);
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] t6_exp [F];
  int base;

  initial begin
    // 1: reset with i_tvalid held high
    do_reset();

    // 2: single beat, latency and consecutive words
    rdy_mode = 0;
    hs_cyc.delete();
    acc_cyc.delete();
    send_beat(64'h0807060504030201, 1'b1);
    wait_drain("t2");
    chk("t2_word_count", 64'(hs_cyc.size()), 64'd8);
    if (hs_cyc.size() > 0 && acc_cyc.size() > 0)
      chk("t2_latency", 64'(hs_cyc[0]), 64'(acc_cyc[0] + 1));
    for (int i = 1; i < hs_cyc.size(); i++)
      chk("t2_consecutive", 64'(hs_cyc[i]), 64'(hs_cyc[0] + i));

    // 3: four beats back-to-back, full frame with no gaps
    do_reset();
    hs_cyc.delete();
    acc_cyc.delete();
    for (int b = 0; b < 4; b++) send_beat({$urandom, $urandom}, 1'b1);
    wait_drain("t3");
    chk("t3_word_count", 64'(hs_cyc.size()), 64'd32);
    chk("t3_accept_count", 64'(acc_cyc.size()), 64'd4);
    if (acc_cyc.size() == 4) begin
      chk("t3_accept2_gap", 64'(acc_cyc[1] - acc_cyc[0]), 64'd1);
      chk("t3_full_stall", 64'(acc_cyc[2] - acc_cyc[1]), 64'(F));
    end
    for (int i = 1; i < hs_cyc.size(); i++)
      chk("t3_no_gap", 64'(hs_cyc[i] - hs_cyc[i-1]), 64'd1);

    // 4: backpressure pattern 1,0,0,1 across a frame
    do_reset();
    pidx = 0;
    rdy_mode = 1;
    for (int b = 0; b < 4; b++) send_beat({$urandom, $urandom}, 1'b1);
    wait_drain("t4");

    // 5: reset after the 13th word, then a fresh frame
    do_reset();
    rdy_mode = 0;
    base = n_pop;
    send_beat({$urandom, $urandom}, 1'b1);
    send_beat({$urandom, $urandom}, 1'b1);
    for (int k = 0; k < 500 && (n_pop - base) < 13; k++) begin
      @(posedge clk);
      #1;
    end
    chk("t5_words_before_reset", 64'(n_pop - base), 64'd13);
    do_reset();
    for (int b = 0; b < 4; b++) send_beat({$urandom, $urandom}, 1'b1);
    wait_drain("t5");

    // 6: signed-clamp beat, expectations written out directly
    do_reset();
`ifdef CONV_SER_RELU_EN
    t6_exp = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h7F};
`else
    t6_exp = '{8'h81, 8'h02, 8'hFE, 8'h00, 8'h01, 8'hFF, 8'h80, 8'h7F};
`endif
    for (int f = 0; f < F; f++) begin
      exp_t e;
      e.dat  = t6_exp[f];
      e.last = 1'b0;
      q.push_back(e);
    end
    send_beat(64'h7F80FF0100FE0281, 1'b0);
    wait_drain("t6");

    // 7: random beats, random idle gaps, random downstream ready, three frames
    do_reset();
    rdy_mode = 2;
    for (int b = 0; b < 3 * PIX; b++) begin
      int n;
      n = $urandom_range(0, 12);
      repeat (n) begin
        @(posedge clk);
        #1;
      end
      send_beat({$urandom, $urandom}, 1'b1);
    end
    wait_drain("t7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
